ps2_rx: RTL and testbench
=========================

Name: ps2_rx

Overview:
- PS/2 keyboard receiver that sits directly upstream of the keyboard matrix block in the ZX48 top level.
- Samples the raw PS/2 clock and data pins, deframes 11-bit frames and strips the E0/F0/E1 prefix bytes.
- Delivers one strobe per key event as kstb/make/code, the interface the top level already consumes, plus ext and perr.
- Runs in the 56 MHz system clock domain; a clock-enable strobe sets the sampling rate.

Parameters:
- TIMEOUT, 7000: number of ce ticks with no PS/2 falling edge, while mid-frame, before the frame is abandoned (~1 ms at 7 MHz).
- CW, 13: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clock  in  1  system clock, 56 MHz
- reset  in  1  asynchronous, active-low reset
- ce     in  1  sampling enable; all state advances only on clock edges where ce=1
- ps2ck  in  1  raw PS/2 clock pin, asynchronous
- ps2d   in  1  raw PS/2 data pin, asynchronous
- kstb   out 1  key-event strobe, high for exactly one clock cycle
- make   out 1  1 = press, 0 = release; valid while kstb=1 and held until the next event
- ext    out 1  1 = E0-prefixed key; valid while kstb=1 and held until the next event
- code   out 8  scan code; valid while kstb=1 and held until the next event
- perr   out 1  one-cycle pulse on a parity error, framing error or timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - kstb=0, make=0, ext=0, code=8'h00, perr=0.
  - State=IDLE; ext/brk flags and skip counter cleared; timeout counter cleared.
  - Synchroniser flops are set to 1 (bus idle high).
- Synchroniser: both pins pass through 2 flops each, clocked on every clock edge (not gated by ce). A third ps2ck stage provides edge history.
- Falling edge (fe) = previous synced ps2ck is 1 and current is 0, evaluated on ce cycles only.
- Receive state machine (advances on fe only):
  - IDLE: data=0 -> DATA with bit count 0. data=1 (spurious start) -> stay in IDLE, no error.
  - DATA: shift data in LSB-first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: frame is good if data=1 and the XOR of the 8 data bits and parity is 1 (odd parity). Either way -> IDLE.
- Frame error (bad stop bit or bad parity):
  - Discard the byte.
  - perr=1 for one clock.
  - Clear the ext, brk and skip state.
- Timeout:
  - The counter resets on every fe and whenever state=IDLE; it increments on ce while not IDLE.
  - On reaching TIMEOUT: force IDLE, discard partial data, pulse perr.
  - A timeout has priority over an fe in the same cycle.
- Byte processing (good frames only), checked in this order:
  - skip!=0: decrement skip. If skip becomes 0, emit kstb with make=1, ext=1, code=8'hE1 (Pause). Otherwise no output.
  - 8'hE1: skip=7, no output.
  - 8'hE0: set ext flag, no output.
  - 8'hF0: set brk flag, no output.
  - Any other byte: emit kstb=1 for one clock with code=byte, make=!brk, ext=ext flag. Clear both flags in the same cycle.
- Emit latency: kstb rises on the clock edge following the ce cycle that detected the stop-bit fe.
  - code, make and ext update on that same edge and are stable before kstb is sampled.
- kstb and perr are never high in the same cycle.
- Repeated prefixes are idempotent: E0 E0 equals E0, and F0 F0 equals F0.
- Typematic repeats are not filtered: each repeated make byte produces its own kstb.
- Host-to-device transmission is out of scope; the pins are input-only.
- Outputs are registered; there are no combinational paths from the pins to any output.

Test Plan:
- Reset release, PS/2 lines idle high for 10000 ce ticks -> no kstb, no perr; code=8'h00.
- Frame 8'h1C ('A'), odd parity bit 0, stop 1 -> exactly one kstb, code=8'h1C, make=1, ext=0; latency of 1 clock after the stop-bit fe.
- Sequence F0 1C, then E0 F0 75 -> first kstb: code=8'h1C, make=0, ext=0; second kstb: code=8'h75, make=0, ext=1; no kstb on any prefix byte.
- Frame 8'h1C with parity flipped, then a good 8'h1C -> one perr pulse and no kstb for the bad frame; the good frame yields kstb, code=8'h1C, make=1.
- Start bit plus 4 data bits, then ps2ck held high -> perr exactly TIMEOUT ce ticks after the last fe, state back to IDLE; a following good frame 8'h29 decodes correctly.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one kstb, code=8'hE1, make=1, ext=1, emitted after the 8th byte; assert reset mid-sequence and verify the next plain 8'h1C decodes with ext=0, make=1.

Source files
------------

// File: rtl/ps2_rx_if.sv
// PS/2 receiver bus: raw pin inputs and the key-event outputs consumed by the
// keyboard matrix block.
interface ps2_rx_if;
  logic       ps2ck;
  logic       ps2d;
  logic       kstb;
  logic       make;
  logic       ext;
  logic [7:0] code;
  logic       perr;

  modport master (output ps2ck, ps2d, input kstb, make, ext, code, perr);
  modport slave  (input ps2ck, ps2d, output kstb, make, ext, code, perr);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames with odd
// parity and folds E0/F0/E1 prefixes into one strobe per key event.
module ps2_rx #(
  parameter int TIMEOUT = 7000,
  parameter int CW      = 13
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     ce,
  ps2_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e          state_q, state_d;
  logic            ck1_q, ck2_q, ck3_q, d1_q, d2_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [CW-1:0]   to_q, to_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [2:0]      skip_q, skip_d;
  logic            kstb_q, kstb_d, make_q, make_d, xout_q, xout_d, perr_q, perr_d;
  logic [7:0]      code_q, code_d;
  logic            fe, timeout, frame_done, frame_good;

  // Edge history advances on ce only, so an edge seen between ce ticks is not lost.
  assign fe      = ce & ck3_q & ~ck2_q;
  assign timeout = ce && (state_q != IDLE) && (to_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: synchroniser flops reset to 1 so a released bus does not look like a falling edge.
      ck1_q     <= 1'b1;
      ck2_q     <= 1'b1;
      ck3_q     <= 1'b1;
      d1_q      <= 1'b1;
      d2_q      <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_q      <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      skip_q    <= '0;
      kstb_q    <= 1'b0;
      make_q    <= 1'b0;
      xout_q    <= 1'b0;
      code_q    <= '0;
      perr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here so every flop samples pre-edge values.
      ck1_q     <= bus.ps2ck;
      ck2_q     <= ck1_q;
      d1_q      <= bus.ps2d;
      d2_q      <= d1_q;
      if (ce) ck3_q <= ck2_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_q      <= to_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      skip_q    <= skip_d;
      kstb_q    <= kstb_d;
      make_q    <= make_d;
      xout_q    <= xout_d;
      code_q    <= code_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_d       = to_q;
    frame_done = 1'b0;
    frame_good = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      to_d    = '0;
    end else if (fe) begin
      to_d = '0;
      unique case (state_q)
        IDLE: if (!d2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {d2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = d2_q;
          state_d = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          frame_good = d2_q & (^shift_q ^ par_q);
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (ce) begin
      to_d = (state_q == IDLE) ? '0 : to_q + CW'(1);
    end
  end

  always_comb begin
    kstb_d = 1'b0;
    perr_d = 1'b0;
    make_d = make_q;
    xout_d = xout_q;
    code_d = code_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    if (timeout) begin
      perr_d = 1'b1;
    end else if (frame_done && !frame_good) begin
      perr_d = 1'b1;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end else if (frame_done) begin
      // Pause sends E1 plus seven bytes; the last of them yields one synthetic event.
      if (skip_q != '0) begin
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          kstb_d = 1'b1;
          make_d = 1'b1;
          xout_d = 1'b1;
          code_d = 8'hE1;
        end
      end else if (shift_q == 8'hE1) begin
        skip_d = 3'd7;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        kstb_d = 1'b1;
        make_d = ~brk_q;
        xout_d = ext_q;
        code_d = shift_q;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end
  end

  assign bus.kstb = kstb_q;
  assign bus.make = make_q;
  assign bus.ext  = xout_q;
  assign bus.code = code_q;
  assign bus.perr = perr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed frames plus randomised byte streams
// compared against a byte-level key-event model.
module tb_ps2_rx;
  localparam int TIMEOUT = 7000;
  localparam int H       = 10;   // half bit period in clocks
  localparam int GAP     = 30;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ce    = 1'b0;
  bit   ce_rand = 1'b0;
  ps2_rx_if bus ();

  ps2_rx #(.TIMEOUT(TIMEOUT), .CW(13)) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc++;

  always @(negedge clock) ce = ce_rand ? (($urandom % 4) != 0) : 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed events
  int unsigned kstb_cnt = 0, perr_cnt = 0, both_cnt = 0;
  int unsigned kstb_cyc = 0, perr_cyc = 0, last_fe_cyc = 0;
  logic [7:0]  ev_code;
  logic        ev_make, ev_ext;

  always @(negedge clock) begin
    if (bus.kstb) begin
      kstb_cnt++;
      kstb_cyc = cyc;
      ev_code  = bus.code;
      ev_make  = bus.make;
      ev_ext   = bus.ext;
    end
    if (bus.perr) begin
      if (perr_cnt == 0) perr_cyc = cyc;
      perr_cnt++;
    end
    if (bus.kstb && bus.perr) both_cnt++;
  end

  // Byte-level reference model
  int   m_skip;
  bit   m_ext, m_brk, m_make, m_xout;
  logic [7:0] m_code;

  function automatic void model_reset();
    m_skip = 0; m_ext = 0; m_brk = 0; m_make = 0; m_xout = 0; m_code = 8'h00;
  endfunction

  function automatic bit model_byte(input logic [7:0] b, input bit good);
    bit stb = 0;
    if (!good) begin
      m_skip = 0; m_ext = 0; m_brk = 0;
    end else if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) begin
        stb = 1; m_code = 8'hE1; m_make = 1; m_xout = 1;
      end
    end else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      stb = 1; m_code = b; m_make = !m_brk; m_xout = m_ext;
      m_ext = 0; m_brk = 0;
    end
    return stb;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_counts();
    @(posedge clock);
    kstb_cnt = 0; perr_cnt = 0;
    @(negedge clock);
  endtask

  task automatic send_bit(input bit v);
    bus.ps2d = v;
    wait_clk(H);
    bus.ps2ck   = 1'b0;
    last_fe_cyc = cyc;
    wait_clk(H);
    bus.ps2ck = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(!bad_stop);
    bus.ps2d = 1'b1;
    wait_clk(GAP);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit bad_par,
                           input bit bad_stop, input bit chk_lat);
    bit good = !bad_par && !bad_stop;
    bit exp_stb;
    clear_counts();
    exp_stb = model_byte(b, good);
    send_frame(b, bad_par, bad_stop);
    check({tag, "_kstb"}, kstb_cnt, {31'd0, exp_stb});
    check({tag, "_perr"}, perr_cnt, {31'd0, !good});
    check({tag, "_code_hold"}, bus.code, m_code);
    if (exp_stb) begin
      check({tag, "_event"}, {ev_code, ev_make, ev_ext}, {m_code, m_make, m_xout});
      if (chk_lat) check({tag, "_latency"}, kstb_cyc - last_fe_cyc, 3);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wait_clk(3);
    check("rst_kstb", bus.kstb, 0);
    check("rst_make", bus.make, 0);
    check("rst_ext",  bus.ext,  0);
    check("rst_code", bus.code, 0);
    check("rst_perr", bus.perr, 0);
    reset = 1'b1;
    model_reset();
    wait_clk(3);
  endtask

  initial begin
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] b;
    int r;
    bus.ps2ck = 1'b1;
    bus.ps2d  = 1'b1;
    do_reset();

    // Idle bus for 10000 ce ticks
    clear_counts();
    wait_clk(10000);
    check("idle_kstb", kstb_cnt, 0);
    check("idle_perr", perr_cnt, 0);
    check("idle_code", bus.code, 0);

    run_frame("a_make", 8'h1C, 0, 0, 1);
    run_frame("pfx_f0", 8'hF0, 0, 0, 1);
    run_frame("a_brk",  8'h1C, 0, 0, 1);
    run_frame("pfx_e0", 8'hE0, 0, 0, 1);
    run_frame("pfx_f0b", 8'hF0, 0, 0, 1);
    run_frame("kp_brk", 8'h75, 0, 0, 1);
    run_frame("dup_e0a", 8'hE0, 0, 0, 1);
    run_frame("dup_e0b", 8'hE0, 0, 0, 1);
    run_frame("dup_key", 8'h6B, 0, 0, 1);
    run_frame("bad_par", 8'h1C, 1, 0, 1);
    run_frame("good_after_par", 8'h1C, 0, 0, 1);
    run_frame("pfx_before_bad", 8'hF0, 0, 0, 1);
    run_frame("bad_stop", 8'h33, 0, 1, 1);
    run_frame("flags_cleared", 8'h33, 0, 0, 1);

    // Partial frame then silence: timeout
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    while (perr_cnt == 0 && cyc < last_fe_cyc + TIMEOUT + 50) wait_clk(1);
    wait_clk(5);
    check("to_perr_count", perr_cnt, 1);
    check("to_latency", perr_cyc - last_fe_cyc, 3 + TIMEOUT);
    check("to_no_kstb", kstb_cnt, 0);
    wait_clk(GAP);
    run_frame("after_to", 8'h29, 0, 0, 1);

    // Full pause sequence
    foreach (pause_seq[i]) run_frame($sformatf("pause%0d", i), pause_seq[i], 0, 0, 1);

    // Reset in the middle of a pause sequence
    for (int i = 0; i < 3; i++) run_frame($sformatf("pmid%0d", i), pause_seq[i], 0, 0, 1);
    do_reset();
    run_frame("post_rst", 8'h1C, 0, 0, 1);

    // Randomised byte stream with sparse ce
    ce_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r = $urandom % 16;
      if (r < 3)       b = 8'hE0;
      else if (r < 6)  b = 8'hF0;
      else if (r == 6) b = 8'hE1;
      else             b = 8'($urandom);
      r = $urandom % 12;
      run_frame($sformatf("rnd%0d", n), b, r == 0, r == 1, 0);
    end
    ce_rand = 1'b0;

    check("no_kstb_perr_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
